// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Single-outstanding data-memory slave. Accepts one load or
//                store at a time, answers it a fixed LATENCY edges later with
//                a one-cycle ack_o, and flags rejected requests (misaligned or
//                beyond DEPTH words) with err_o. Requests that arrive while a
//                request is pending are dropped and recorded in a sticky
//                overrun_o flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 256,   // number of 32-bit words stored
    parameter int LATENCY = 3      // edges from acceptance to ack_o, 1..15
) (
    input  logic        clk_i,
    input  logic        rst_i,      // asynchronous, active-low
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        overrun_o
);

    // Word-index width; kept at least 1 so a single-word memory still elaborates.
    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] C_DEPTH    = 32'(DEPTH);
    // The counter is loaded with LATENCY-1 so that the WAIT->RESP edge is the
    // LATENCY-th edge after the accepting one.
    localparam logic [3:0]  C_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;
    logic        overrun_q;
    logic [31:0] rdata_q;

    // Storage has no reset: its contents must survive rst_i.
    logic [31:0] mem_q [DEPTH];

    logic [29:0] word_d;
    logic [AW-1:0] idx_d;
    logic        reject_d;
    logic        fire_d;
    logic        mem_we_d;
    logic [31:0] rdata_d;

    // Decode the latched request and decide what happens at the WAIT->RESP edge.
    always_comb begin
        word_d   = addr_q[31:2];
        idx_d    = word_d[AW-1:0];
        reject_d = (addr_q[1:0] != 2'b00) || ({2'b00, word_d} >= C_DEPTH);
        fire_d   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
        mem_we_d = fire_d && we_q && !reject_d;
        // Stores and rejected requests return zero; only a good load reads.
        rdata_d  = (we_q || reject_d) ? 32'd0 : mem_q[idx_d];
    end

    // Memory write port; an async reset forces IDLE, so an aborted store
    // never reaches this write.
    always_ff @(posedge clk_i) begin
        if (mem_we_d) begin
            mem_q[idx_d] <= wdata_q;
        end
    end

    // Request FSM with registered response outputs and sticky overrun flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= C_CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (req_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (fire_d) begin
                        ack_q   <= 1'b1;
                        err_q   <= reject_d;
                        rdata_q <= rdata_d;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (req_i) begin
                        overrun_q <= 1'b1;
                    end
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign overrun_o = overrun_q;

endmodule
`default_nettype wire
